// File: rtl/seg7_digit_presenter_if.sv
// Digit handshake between the upstream digit generator and the presenter.
// Master drives code/valid, slave answers with ready.
interface seg7_digit_presenter_if;
  logic [3:0] in_code;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_code,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_code,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/seg7_digit_presenter.sv
// Buffers digit codes and shows each on a 7-segment display for a fixed
// hold time, then a blank gap. Optional: DIGIT_DP_MARK_EN marks first digit.
module seg7_digit_presenter #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  seg7_digit_presenter_if.slave       in_if,
  output logic [7:0]                  segments,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  logic [3:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [3:0]  head;
  logic [6:0]  head_pat;
  logic        dp_mark;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  seg_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    logic [6:0] p;
    case (c)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = in_if.in_valid && !full && !reset;
  assign in_if.in_ready = !full;

  assign head     = mem_q[rd_q[AW-1:0]];
  assign head_pat = seg_decode(head);

  // Pop whenever a slot boundary is reached with a digit waiting.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = !empty;
      SHOW:    pop = !empty && (cnt_q == 8'd0) && NO_GAP;
      GAP:     pop = !empty && (cnt_q == 8'd0);
      default: pop = 1'b0;
    endcase
  end

  // Digit storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= in_if.in_code;
    end
  end

  // Write pointer advances on every accepted digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
    end else if (push) begin
      wr_q <= wr_q + 1'b1;
    end
  end

`ifdef DIGIT_DP_MARK_EN
  logic first_q;

  // First digit after reset is always loaded from IDLE.
  assign dp_mark = first_q && (state_q == IDLE);

  // Flag drops once the first digit leaves SHOW.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= 1'b1;
    end else if (state_q == SHOW && cnt_q == 8'd0) begin
      first_q <= 1'b0;
    end
  end
`else
  assign dp_mark = 1'b0;
`endif

  // Display sequencer: IDLE -> SHOW (hold) -> GAP (blank) -> next or IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seg_q   <= '0;
      rd_q    <= '0;
    end else if (pop) begin
      state_q <= SHOW;
      cnt_q   <= HOLD_LD;
      seg_q   <= {dp_mark, head_pat};
      rd_q    <= rd_q + 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          seg_q <= '0;
        end
        SHOW: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!NO_GAP) begin
            state_q <= GAP;
            cnt_q   <= GAP_LD;
            seg_q   <= '0;
          end else begin
            state_q <= IDLE;
            seg_q   <= '0;
          end
        end
        GAP: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
            seg_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          seg_q   <= '0;
        end
      endcase
    end
  end

  assign segments = seg_q;
  assign busy     = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_seg7_digit_presenter.sv
// Bench for seg7_digit_presenter: slot-timeline reference model,
// decode table, directed corner sequences and random traffic.
module tb_seg7_digit_presenter;

`ifdef DIGIT_DP_MARK_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  localparam int NS = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic valid = 1'b0;
  logic [3:0] code = 4'd0;
  logic [7:0] seg0, seg1;
  logic busy0, busy1;

  always #5 clk = ~clk;

  seg7_digit_presenter_if bus0 ();
  seg7_digit_presenter_if bus1 ();

  assign bus0.in_code  = code;
  assign bus0.in_valid = valid;
  assign bus1.in_code  = code;
  assign bus1.in_valid = valid;

  seg7_digit_presenter dut0 (
    .clk      (clk),
    .reset    (reset),
    .in_if    (bus0),
    .segments (seg0),
    .busy     (busy0)
  );

  seg7_digit_presenter #(
    .HOLD_CYCLES (3),
    .GAP_CYCLES  (0),
    .FIFO_DEPTH  (2)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .in_if    (bus1),
    .segments (seg1),
    .busy     (busy1)
  );

  typedef struct {
    logic [3:0] code;
    logic [7:0] seg;
  } vec_t;

  logic [7:0] dec_tab [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  int hold_p [2] = '{8, 3};
  int gap_p  [2] = '{2, 0};
  int dep_p  [2] = '{4, 2};

  int         s_acc   [2][NS];
  int         s_ld    [2][NS];
  logic [3:0] s_code  [2][NS];
  bit         s_first [2][NS];
  int         hd [2];
  int         tl [2];
  int         last_end [2];
  bit         first_pend [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, got, exp, cyc);
    end
  endtask

  function automatic int occ(int i, int m);
    int c = 0;
    for (int k = hd[i]; k != tl[i]; k = (k + 1) % NS)
      if (s_acc[i][k] <= m && s_ld[i][k] > m) c++;
    return c;
  endfunction

  function automatic int exp_seg(int i, int n);
    int r = 0;
    for (int k = hd[i]; k != tl[i]; k = (k + 1) % NS)
      if (s_ld[i][k] <= n && n < s_ld[i][k] + hold_p[i])
        r = dec_tab[s_code[i][k]] |
            ((s_first[i][k] && DP) ? 8'h80 : 8'h00);
    return r;
  endfunction

  function automatic int exp_busy(int i, int n);
    int r = 0;
    for (int k = hd[i]; k != tl[i]; k = (k + 1) % NS)
      if (s_acc[i][k] <= n &&
          n < s_ld[i][k] + hold_p[i] + gap_p[i]) r = 1;
    return r;
  endfunction

  task automatic model_update();
    int n;
    int ld;
    cyc++;
    n = cyc;
    for (int i = 0; i < 2; i++) begin
      while (hd[i] != tl[i] &&
             s_ld[i][hd[i]] + hold_p[i] + gap_p[i] < n - 1)
        hd[i] = (hd[i] + 1) % NS;
      if (reset) begin
        hd[i] = 0;
        tl[i] = 0;
        last_end[i] = 0;
        first_pend[i] = 1'b1;
      end else if (valid && occ(i, n - 1) < dep_p[i]) begin
        ld = (n + 1 > last_end[i]) ? n + 1 : last_end[i];
        s_acc[i][tl[i]]   = n;
        s_ld[i][tl[i]]    = ld;
        s_code[i][tl[i]]  = code;
        s_first[i][tl[i]] = first_pend[i];
        first_pend[i] = 1'b0;
        last_end[i] = ld + hold_p[i] + gap_p[i];
        tl[i] = (tl[i] + 1) % NS;
      end
    end
  endtask

  task automatic model_check();
    chk("seg0",   int'(seg0),  exp_seg(0, cyc));
    chk("busy0",  int'(busy0), exp_busy(0, cyc));
    chk("ready0", int'(bus0.in_ready),
        (occ(0, cyc) < dep_p[0]) ? 1 : 0);
    chk("seg1",   int'(seg1),  exp_seg(1, cyc));
    chk("busy1",  int'(busy1), exp_busy(1, cyc));
    chk("ready1", int'(bus1.in_ready),
        (occ(1, cyc) < dep_p[1]) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (chk_en) model_check();
  endtask

  task automatic push(input logic [3:0] c);
    valid = 1'b1;
    code = c;
    step();
    valid = 1'b0;
  endtask

  task automatic push_hold(input logic [3:0] c, output int edge_n);
    bit done = 1'b0;
    bit r;
    edge_n = -1;
    valid = 1'b1;
    code = c;
    for (int t = 0; t < 200 && !done; t++) begin
      r = bus0.in_ready;
      step();
      if (r) begin
        done = 1'b1;
        edge_n = cyc;
      end
    end
    valid = 1'b0;
    if (!done) chk("push_hold_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy0 || busy1) && t < 300) begin
      step();
      t++;
    end
    if (busy0 || busy1) chk("idle_timeout", 1, 0);
  endtask

  vec_t tab [16];

  initial begin
    int k;
    int e5;

    tab = '{
      '{4'd0, 8'h3F}, '{4'd1, 8'h06}, '{4'd2, 8'h5B}, '{4'd3, 8'h4F},
      '{4'd4, 8'h66}, '{4'd5, 8'h6D}, '{4'd6, 8'h7D}, '{4'd7, 8'h07},
      '{4'd8, 8'h7F}, '{4'd9, 8'h6F}, '{4'd10, 8'h00}, '{4'd11, 8'h00},
      '{4'd12, 8'h00}, '{4'd13, 8'h00}, '{4'd14, 8'h00}, '{4'd15, 8'h00}
    };

    // reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_seg", int'(seg0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ready", int'(bus0.in_ready), 1);

    // first digit 3 after reset, dp mark if enabled
    push(4'd3);
    step();
    for (int j = 0; j < 8; j++) begin
      chk("first3", int'(seg0), DP ? 8'hCF : 8'h4F);
      step();
    end
    chk("first3_gap", int'(seg0), 0);
    step();
    chk("first3_gap2", int'(seg0), 0);
    chk("first3_busy", int'(busy0), 1);
    step();
    chk("first3_idle", int'(busy0), 0);

    // decode table
    for (int i = 0; i < 16; i++) begin
      wait_idle();
      push(tab[i].code);
      step();
      chk("decode", int'(seg0), int'(tab[i].seg));
      chk("decode_busy", int'(busy0), 1);
    end

    // 1,1 back to back: separate slots
    wait_idle();
    push(4'd1);
    push(4'd1);
    for (int j = 1; j <= 18; j++) begin
      chk("one_one", int'(seg0),
          (j <= 8 || j >= 11) ? 8'h06 : 8'h00);
      step();
    end

    // fill buffer while showing
    wait_idle();
    push(4'd8);
    k = cyc;
    step();
    for (int j = 0; j < 4; j++) push_hold(4'(2 + j), e5);
    chk("full_ready", int'(bus0.in_ready), 0);
    push_hold(4'd6, e5);
    chk("fifth_accept_edge", e5, k + 12);

    // zero gap instance: 4 then 0 seamlessly
    wait_idle();
    push(4'd4);
    push(4'd0);
    for (int j = 1; j <= 7; j++) begin
      chk("nogap", int'(seg1),
          (j <= 3) ? 8'h66 : (j <= 6) ? 8'h3F : 8'h00);
      step();
    end

    // blank code still takes a slot
    wait_idle();
    push(4'd12);
    step();
    for (int j = 0; j < 10; j++) begin
      chk("blank_seg", int'(seg0), 0);
      chk("blank_busy", int'(busy0), 1);
      step();
    end
    chk("blank_done", int'(busy0), 0);

    // reset during SHOW with buffered digits, push ignored on reset
    wait_idle();
    push(4'd7);
    push(4'd1);
    push(4'd2);
    step();
    reset = 1'b1;
    valid = 1'b1;
    code = 4'd5;
    step();
    reset = 1'b0;
    valid = 1'b0;
    chk("midrst_seg", int'(seg0), 0);
    chk("midrst_busy", int'(busy0), 0);
    step();
    chk("midrst_seg2", int'(seg0), 0);
    push(4'd9);
    step();
    chk("after_rst9", int'(seg0), DP ? 8'hEF : 8'h6F);

    // random traffic against the model
    for (int t = 0; t < 3000; t++) begin
      valid = ($urandom_range(0, 2) != 0);
      code = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    valid = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
